hamm_codec: RTL and testbench
=============================

# hamm_codec

Hamming SECDED (8,4) codec: 4-bit data words are encoded into 8-bit codewords (Hamming(7,4) plus overall parity), and 8-bit codewords are decoded back to 4-bit data with single-error correction and double-error detection. The block is the top-level wrapper for two independent registered submodules, `hamm_encoder` and `hamm_decoder`. It sits on the data path between a 4-bit source and an 8-bit channel or storage. The encoder output feeds the decoder input externally, so the system can be looped back.

## Interface
- Parameters: none. Widths are fixed at 4-bit data and 8-bit codeword.
- One clock; reset is asynchronous and active-low. Clock port is `clk`, reset port is `reset`.
- `clk`  input  1  rising-edge clock for all registers.
- `reset`  input  1  asynchronous, active-low; clears all output registers.
- `enc_in`  input  4  data to encode; maps to `hamm_encoder.in`.
- `enc_out`  output  8  registered codeword; maps to `hamm_encoder.out`.
- `dec_in`  input  8  received codeword; maps to `hamm_decoder.out`, an input despite its name.
- `dec_out`  output  4  registered, corrected data; maps to `hamm_decoder.in`, an output despite its name.
- `dec_single_err`  output  1  registered flag: a single-bit error was corrected.
- `dec_double_err`  output  1  registered flag: an uncorrectable double-bit error was detected.

## Operation
- Data bits: d0..d3 = `enc_in[0..3]`.
- Parity bits:
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p4 = d1^d2^d3
- Codeword layout, where bit i holds Hamming position i+1:
  - `[0]` = p1, `[1]` = p2, `[2]` = d0, `[3]` = p4
  - `[4]` = d1, `[5]` = d2, `[6]` = d3
  - `[7]` = XOR of bits `[6:0]`, giving even overall parity.
- Decoder, with c = `dec_in`:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - syndrome s = {s4,s2,s1}
  - pa = XOR of all 8 bits of c.
- Decode cases:
  - s=0, pa=0: no error. `dec_out` = {c6,c5,c4,c2}; both flags 0.
  - pa=1, s≠0: single error at c[s-1]. Flip that bit, then extract data; `dec_single_err`=1.
  - pa=1, s=0: error in c7 only. Data as received; `dec_single_err`=1.
  - pa=0, s≠0: double error. `dec_out` = uncorrected data bits; `dec_double_err`=1; `dec_single_err`=0.
- `dec_single_err` and `dec_double_err` are never 1 in the same cycle.
- Errors of three or more bits are not detected reliably; the decoder applies the same rules without special handling.
- Encoder and decoder share no state and operate independently in every cycle.

## Timing
- Encoder: `enc_out` updates on the rising edge after `enc_in` is sampled; latency 1 cycle.
- Decoder: `dec_out` and both flags update on the rising edge after `dec_in` is sampled; latency 1 cycle.
- Loopback (`enc_out` wired to `dec_in`): 2-cycle latency from `enc_in` to `dec_out`.
- No handshake. A new word is accepted every cycle; inputs are assumed stable around the rising edge.
- Reset asserted low:
  - `enc_out`, `dec_out`, `dec_single_err` and `dec_double_err` go to 0 immediately, without waiting for a clock edge.
  - They hold 0 while reset is low.
  - Reset asserted mid-stream discards in-flight words.
- After reset deasserts, the first rising edge loads the current inputs.
- Note: the all-zero codeword 0x00 is valid for data 0, so the reset state is consistent.

## Test plan
- Reset: drive `reset`=0 with arbitrary inputs -> all outputs 0 asynchronously. Release reset with `enc_in`=4'hB -> `enc_out`=8'h55 one cycle later.
- Encode sweep: apply `enc_in` 0..15, one value per cycle, looped back -> `enc_out` is 8'h00 for 0, 8'h87 for 1, 8'h55 for 4'hB, 8'hFF for 4'hF. `dec_out` equals the input 2 cycles later; flags stay 0.
- Single error: `dec_in`=8'h45 (0x55 with bit 4 flipped) -> `dec_out`=4'hB, `dec_single_err`=1, `dec_double_err`=0.
- Parity-bit error: `dec_in`=8'hD5 (0x55 with bit 7 flipped) -> `dec_out`=4'hB, `dec_single_err`=1.
- Double error: `dec_in`=8'h56 (bits 0 and 1 of 0x55 flipped) -> `dec_double_err`=1, `dec_single_err`=0, `dec_out`=4'hB (uncorrected data bits).
- Exhaustive single-bit check: for every data value and every bit i from 0 to 7, feed the codeword with bit i flipped -> data recovered and `dec_single_err`=1. Also apply reset mid-stream -> outputs return to 0 immediately.

Source files
------------

// File: rtl/hamm_codec.sv
// Hamming SECDED (8,4) codec: a registered encoder and a registered decoder
// sharing only clock and reset. Codeword bit i holds Hamming position i+1,
// and bit 7 carries even overall parity.

// Encoder: 4-bit data in, 8-bit SECDED codeword out, one cycle of latency.
module hamm_encoder (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] in,
   output logic [7:0] out
);

   // Build the codeword: parity bits at positions 1, 2 and 4, data at 3, 5, 6, 7,
   // then the overall parity bit on top.
   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [6:0] h;
      h = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
           d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
      return {^h, h};
   endfunction

   // Codeword register; reset clears it to 0x00, which is the valid codeword for data 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) out <= '0;
      else        out <= encode(in);
   end

endmodule

// Decoder: 8-bit received codeword in, corrected 4-bit data and error flags out.
// The port names follow the wrapper mapping: "out" is the codeword input and
// "in" is the data output.
module hamm_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] out,
   output logic [3:0] in,
   output logic       single_err,
   output logic       double_err
);

   logic [2:0] syn_p0;
   logic       par_p0;
   logic [6:0] fixed_p0;

   // Syndrome and overall parity; with odd parity the syndrome names the bit to
   // flip, and a zero syndrome means only the parity bit itself was hit.
   always_comb begin
      syn_p0   = {out[3] ^ out[4] ^ out[5] ^ out[6],
                  out[1] ^ out[2] ^ out[5] ^ out[6],
                  out[0] ^ out[2] ^ out[4] ^ out[6]};
      par_p0   = ^out;
      fixed_p0 = out[6:0];
      if (par_p0) begin
         for (int i = 0; i < 7; i++) begin
            if (syn_p0 == 3'(i + 1)) fixed_p0[i] = ~out[i];
         end
      end
   end

   // ---- stage boundary: p0 -> registered outputs ----
   // Output registers; a double error passes the data bits through uncorrected.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in         <= '0;
         single_err <= 1'b0;
         double_err <= 1'b0;
      end else begin
         in         <= {fixed_p0[6], fixed_p0[5], fixed_p0[4], fixed_p0[2]};
         single_err <= par_p0;
         double_err <= !par_p0 && (syn_p0 != 3'd0);
      end
   end

endmodule

// Top-level wrapper exposing the encoder and decoder side by side.
module hamm_codec (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] enc_in,
   output logic [7:0] enc_out,
   input  logic [7:0] dec_in,
   output logic [3:0] dec_out,
   output logic       dec_single_err,
   output logic       dec_double_err
);

   hamm_encoder u_enc (
      .clk   (clk),
      .reset (reset),
      .in    (enc_in),
      .out   (enc_out)
   );

   hamm_decoder u_dec (
      .clk        (clk),
      .reset      (reset),
      .out        (dec_in),
      .in         (dec_out),
      .single_err (dec_single_err),
      .double_err (dec_double_err)
   );

endmodule

// File: tb/tb_hamm_codec.sv
// Self-checking bench for hamm_codec: directed steps plus randomized words,
// compared against a position-based SECDED reference model.
module tb_hamm_codec;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] enc_in = '0;
   logic [7:0] enc_out;
   logic [7:0] dec_in;
   logic [7:0] dec_drv = '0;
   logic       loopback = 1'b0;
   logic [3:0] dec_out;
   logic       dec_single_err;
   logic       dec_double_err;

   int checks = 0;
   int errors = 0;

   assign dec_in = loopback ? enc_out : dec_drv;

   always #5 clk = ~clk;

   hamm_codec dut (
      .clk            (clk),
      .reset          (reset),
      .enc_in         (enc_in),
      .enc_out        (enc_out),
      .dec_in         (dec_in),
      .dec_out        (dec_out),
      .dec_single_err (dec_single_err),
      .dec_double_err (dec_double_err)
   );

   // Reference encoder: place data at non-power-of-two positions, then each
   // parity bit at position p covers every other position whose index has bit p set.
   function automatic logic [7:0] ref_enc(input logic [3:0] d);
      logic [7:0] cw;
      int dpos[4] = '{3, 5, 6, 7};
      int ppos[3] = '{1, 2, 4};
      logic acc;
      cw = '0;
      for (int k = 0; k < 4; k++) cw[dpos[k] - 1] = d[k];
      for (int k = 0; k < 3; k++) begin
         acc = 1'b0;
         for (int pos = 1; pos <= 7; pos++)
            if (((pos & ppos[k]) != 0) && (pos != ppos[k])) acc ^= cw[pos - 1];
         cw[ppos[k] - 1] = acc;
      end
      cw[7] = ^cw[6:0];
      return cw;
   endfunction

   // Reference decoder by nearest-codeword search: odd weight words sit at
   // distance 1 from exactly one codeword; even weight non-codewords are doubles.
   task automatic ref_dec(input logic [7:0] cw, output logic [3:0] data,
                          output logic sgl, output logic dbl);
      logic [7:0] c;
      c    = cw;
      data = {c[6], c[5], c[4], c[2]};
      sgl  = 1'b0;
      dbl  = 1'b0;
      if (^c) begin
         sgl = 1'b1;
         for (int d = 0; d < 16; d++)
            if ($countones(ref_enc(4'(d)) ^ c) == 1) data = 4'(d);
      end else begin
         dbl = 1'b1;
         for (int d = 0; d < 16; d++)
            if (ref_enc(4'(d)) == c) begin
               data = 4'(d);
               dbl  = 1'b0;
            end
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dec(input string tag, input logic [7:0] cw);
      logic [3:0] d;
      logic s, b;
      ref_dec(cw, d, s, b);
      check({tag, "_data"}, {4'h0, dec_out}, {4'h0, d});
      check({tag, "_single"}, {7'h0, dec_single_err}, {7'h0, s});
      check({tag, "_double"}, {7'h0, dec_double_err}, {7'h0, b});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_enc"}, enc_out, 8'h00);
      check({tag, "_dec"}, {4'h0, dec_out}, 8'h00);
      check({tag, "_flags"}, {6'h0, dec_single_err, dec_double_err}, 8'h00);
   endtask

   initial begin
      logic [3:0] prev;
      logic [7:0] cw;
      logic [3:0] d;

      // Asynchronous reset with arbitrary inputs, before any clock edge
      enc_in  = 4'($urandom);
      dec_drv = 8'($urandom);
      #1 reset = 1'b0;
      #1 check_zero("reset_async");
      repeat (2) @(posedge clk);
      #1 check_zero("reset_hold");

      // Release with 0xB: first edge loads it
      @(negedge clk);
      reset  = 1'b1;
      enc_in = 4'hB;
      @(posedge clk);
      #1 check("release_enc", enc_out, 8'h55);

      // Loopback sweep over all data values
      loopback = 1'b1;
      prev = 4'hB;
      for (int v = 0; v < 17; v++) begin
         @(negedge clk);
         enc_in = 4'(v);
         @(posedge clk);
         #1;
         if (v < 16) check("sweep_enc", enc_out, ref_enc(4'(v)));
         if (v == 0)  check("enc_0", enc_out, 8'h00);
         if (v == 1)  check("enc_1", enc_out, 8'h87);
         if (v == 11) check("enc_B", enc_out, 8'h55);
         if (v == 15) check("enc_F", enc_out, 8'hFF);
         check("loop_data", {4'h0, dec_out}, {4'h0, prev});
         check("loop_flags", {6'h0, dec_single_err, dec_double_err}, 8'h00);
         prev = 4'(v);
      end

      // Directed error patterns on the decoder
      loopback = 1'b0;
      @(negedge clk); dec_drv = 8'h45;
      @(posedge clk); #1;
      check("single_data", {4'h0, dec_out}, 8'h0B);
      check("single_flag", {6'h0, dec_single_err, dec_double_err}, 8'h02);
      @(negedge clk); dec_drv = 8'hD5;
      @(posedge clk); #1;
      check("par_data", {4'h0, dec_out}, 8'h0B);
      check("par_flag", {6'h0, dec_single_err, dec_double_err}, 8'h02);
      @(negedge clk); dec_drv = 8'h56;
      @(posedge clk); #1;
      check("double_data", {4'h0, dec_out}, 8'h0B);
      check("double_flag", {6'h0, dec_single_err, dec_double_err}, 8'h01);

      // Every data value with every single bit flipped
      for (int dv = 0; dv < 16; dv++) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cw = ref_enc(4'(dv)) ^ (8'h01 << i);
            dec_drv = cw;
            @(posedge clk); #1;
            check("flip_data", {4'h0, dec_out}, 8'(dv));
            check("flip_flag", {6'h0, dec_single_err, dec_double_err}, 8'h02);
         end
      end

      // Randomized independent encoder and decoder traffic
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         d       = 4'($urandom);
         enc_in  = d;
         cw      = 8'($urandom);
         if (n % 3 == 0) cw = ref_enc(4'($urandom)) ^ (8'h01 << $urandom_range(7, 0))
                                                     ^ (8'h01 << $urandom_range(7, 0));
         dec_drv = cw;
         @(posedge clk); #1;
         check("rand_enc", enc_out, ref_enc(d));
         check_dec("rand_dec", cw);
      end

      // Reset mid-stream discards in-flight words
      @(negedge clk);
      enc_in  = 4'hF;
      dec_drv = 8'hD5;
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_zero("mid_reset");
      @(posedge clk);
      #1 check_zero("mid_reset_hold");
      @(negedge clk);
      reset   = 1'b1;
      enc_in  = 4'h1;
      dec_drv = 8'h87;
      @(posedge clk); #1;
      check("post_reset_enc", enc_out, 8'h87);
      check_dec("post_reset_dec", 8'h87);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
